// File: rtl/demux4_reg.sv
// demux4_reg: routes a valid/ready input word to one of four lanes by sel.
// Each lane is a one-entry holding register with its own valid/ready handshake.
module demux4_reg #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           sel,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [7:0]           accept_cnt
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             load;

  // A lane may take a new word when empty or when it drains on the same edge.
  always_comb begin
    in_ready = !valid_q[sel] | out_ready[sel];
    load     = in_valid & in_ready;
    data_d   = data_q;
    valid_d  = valid_q & ~out_ready;
    cnt_d    = cnt_q;
    if (load) begin
      data_d[sel]  = in_data;
      valid_d[sel] = 1'b1;
      cnt_d        = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= 4'b0000;
      cnt_q   <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_lane
    assign out_data[n*WIDTH +: WIDTH] = data_q[n];
  end

  assign out_valid  = valid_q;
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux4_reg.sv
// tb_demux4_reg: directed checks of demux4_reg routing, backpressure,
// drain, counter wrap and asynchronous reset.
module tb_demux4_reg;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [7:0]         accept_cnt;

  int total_checks;
  int bad_checks;

  demux4_reg #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
  task automatic applyStimulus(input logic [1:0] s, input logic [WIDTH-1:0] d,
                               input logic v, input logic [3:0] r);
    sel       = s;
    in_data   = d;
    in_valid  = v;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] route_vals [4];

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    route_vals[0] = 4'd9;
    route_vals[1] = 4'd4;
    route_vals[2] = 4'd2;
    route_vals[3] = 4'd6;

    rst = 1'b1; sel = 2'd0; in_data = '0; in_valid = 1'b0; out_ready = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_data", 32'(out_data), 32'h0);
    checkOutput("rst_cnt", 32'(accept_cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      checkOutput($sformatf("rst_ready_sel%0d", i), 32'(in_ready), 32'h1);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'(i), route_vals[i], 1'b1, 4'b0000);
    end
    in_valid = 1'b0;
    checkOutput("route_valid", 32'(out_valid), 32'hF);
    checkOutput("route_data", 32'(out_data), 32'h6249);
    checkOutput("route_cnt", 32'(accept_cnt), 32'd4);
    sel = 2'd0;
    #1;
    checkOutput("route_full_ready", 32'(in_ready), 32'h0);

    sel = 2'd2; in_data = 4'hA; in_valid = 1'b1; out_ready = 4'b0000;
    #1;
    checkOutput("bp_ready_low", 32'(in_ready), 32'h0);
    applyStimulus(2'd2, 4'hA, 1'b1, 4'b0000);
    checkOutput("bp_hold_data", 32'(out_data), 32'h6249);
    checkOutput("bp_hold_cnt", 32'(accept_cnt), 32'd4);
    out_ready = 4'b0100;
    #1;
    checkOutput("bp_ready_high", 32'(in_ready), 32'h1);
    applyStimulus(2'd2, 4'hA, 1'b1, 4'b0100);
    checkOutput("bp_reload_data", 32'(out_data), 32'h6A49);
    checkOutput("bp_reload_valid", 32'(out_valid), 32'hF);
    checkOutput("bp_reload_cnt", 32'(accept_cnt), 32'd5);

    applyStimulus(2'd0, 4'hF, 1'b0, 4'b1001);
    checkOutput("drain_valid", 32'(out_valid), 32'h6);
    checkOutput("drain_mid_data", 32'(out_data[11:4]), 32'hA4);
    checkOutput("drain_cnt", 32'(accept_cnt), 32'd5);

    // Lane 0 is empty and ready here, but in_valid low must not load it.
    applyStimulus(2'd0, 4'hF, 1'b0, 4'b0000);
    checkOutput("idle_valid", 32'(out_valid), 32'h6);
    checkOutput("idle_cnt", 32'(accept_cnt), 32'd5);

    for (int i = 0; i < 251; i++) begin
      applyStimulus(2'(i % 4), 4'(i), 1'b1, 4'b1111);
      if (i == 249) checkOutput("wrap_cnt_255", 32'(accept_cnt), 32'd255);
    end
    in_valid = 1'b0; out_ready = 4'b0000;
    checkOutput("wrap_cnt_0", 32'(accept_cnt), 32'd0);
    checkOutput("wrap_valid", 32'(out_valid), 32'h4);
    checkOutput("wrap_lane2", 32'(out_data[11:8]), 32'hA);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'(i), 4'(i + 1), 1'b1, 4'b0000);
    end
    in_valid = 1'b0;
    checkOutput("pre_arst_valid", 32'(out_valid), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'h0);
    checkOutput("arst_data", 32'(out_data), 32'h0);
    checkOutput("arst_cnt", 32'(accept_cnt), 32'h0);
    #2;
    rst = 1'b0;
    sel = 2'd3;
    #1;
    checkOutput("post_arst_ready", 32'(in_ready), 32'h1);
    applyStimulus(2'd1, 4'd7, 1'b1, 4'b0000);
    in_valid = 1'b0;
    checkOutput("post_arst_valid", 32'(out_valid), 32'h2);
    checkOutput("post_arst_data", 32'(out_data), 32'h0070);
    checkOutput("post_arst_cnt", 32'(accept_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/demux4_reg.md
DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the data width of the input and of each output lane.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port sel, input, 2 bits: destination lane index 0..3 for the current input word.
REQ-005 The module SHALL have port in_data, input, WIDTH bits: the input word.
REQ-006 The module SHALL have port in_valid, input, 1 bit: in_data and sel are valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the module can accept the word this cycle.
REQ-008 The module SHALL have port out_data, output, 4*WIDTH bits: lane n SHALL occupy bits [n*WIDTH +: WIDTH].
REQ-009 The module SHALL have port out_valid, output, 4 bits: bit n means lane n holds a word.
REQ-010 The module SHALL have port out_ready, input, 4 bits: bit n means the lane n consumer accepts the word this cycle.
REQ-011 The module SHALL have port accept_cnt, output, 8 bits: count of accepted input words.

Function
REQ-012 Each lane n SHALL contain a one-entry holding register (data_n, valid_n) driving out_data lane n and out_valid[n].
REQ-013 in_ready SHALL be combinational: in_ready = !out_valid[sel] | out_ready[sel], independent of in_valid.
REQ-014 An input transfer SHALL occur in a cycle where in_valid & in_ready; on that edge data_sel <= in_data and valid_sel <= 1.
REQ-015 Latency SHALL be one cycle: a word accepted at edge k SHALL be visible on its lane, with out_valid set, from edge k onward.
REQ-016 An output transfer on lane n SHALL occur in a cycle where out_valid[n] & out_ready[n]; on that edge valid_n SHALL clear unless lane n is reloaded on the same edge.
REQ-017 A simultaneous output transfer and input transfer on the same lane SHALL leave valid_n = 1 with the new data, and the old word SHALL be consumed exactly once.
REQ-018 A lane that is valid and not ready SHALL hold data_n stable.
REQ-019 Lanes not addressed by sel SHALL be unaffected by the input, and no other lane SHALL be overwritten.
REQ-020 At most one lane SHALL load per cycle; any number of lanes MAY drain in the same cycle.
REQ-021 When in_valid = 0, no lane SHALL load, even if in_ready = 1.
REQ-022 accept_cnt SHALL increment by 1 on every input transfer and SHALL wrap from 255 to 0.
REQ-023 Blocking on lane sel SHALL NOT drop the input word; the word SHALL be held by the source until in_ready.
REQ-024 The module SHALL hold no other state; there SHALL be no arbitration beyond sel.

Reset
REQ-025 While rst = 1, out_valid SHALL be 4'b0000, all lane data SHALL be 0, and accept_cnt SHALL be 0, taking effect immediately without waiting for clk.
REQ-026 Reset asserted mid-operation SHALL discard all held words; no out_valid SHALL remain set.
REQ-027 After rst deasserts, the first rising edge SHALL operate normally; in_ready SHALL be 1 for any sel.

Verification
REQ-028 Reset then idle: rst pulse -> out_valid=0000, out_data=0, accept_cnt=0, in_ready=1.
REQ-029 Route all lanes (WIDTH=4) with out_ready=0000: sel=0..3 with in_data=9,4,2,6 on consecutive cycles -> out_valid=1111, lanes hold 9,4,2,6, accept_cnt=4.
REQ-030 Backpressure: lane 2 full with out_ready[2]=0, sel=2, in_valid=1, in_data=A -> in_ready=0, lane 2 holds its old word, accept_cnt is unchanged; then raise out_ready[2] -> same-edge drain and reload, lane 2 = A, out_valid[2] stays 1.
REQ-031 Drain: lanes 0 and 3 valid, out_ready=1001 for one cycle with in_valid=0 -> out_valid bits 0 and 3 clear, other lanes are unchanged.
REQ-032 Counter wrap: 256 accepted words -> accept_cnt returns to 0.
REQ-033 Asynchronous reset mid-stream: rst asserted between clock edges with lanes valid -> out_valid=0000 before the next edge.
